// File: rtl/script_stack_ctrl.sv
// Operand stack and sequencer in front of the script ALU: pops operands, waits for
// the ALU, serves extra pop requests and pushes results back onto the stack.
module script_stack_ctrl #(
  parameter int WIDTH   = 512,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 1048575
) (
  input  logic                     i_gclk,
  input  logic                     i_grst_n,
  input  logic                     i_push_valid,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_exec_valid,
  input  logic [1:0]               i_exec_nargs,
  output logic                     o_exec_ready,
  output logic                     o_exec_done,
  output logic                     o_exec_error,
  output logic                     o_push_error,
  output logic [$clog2(DEPTH):0]   o_depth,
  output logic                     o_put_alu_in1,
  output logic                     o_put_alu_in2,
  output logic [WIDTH-1:0]         o_data_alu_in1,
  output logic [WIDTH-1:0]         o_data_alu_in2,
  input  logic                     i_put_alu_out1,
  input  logic                     i_put_alu_out2,
  input  logic [WIDTH-1:0]         i_data_alu_out1,
  input  logic [WIDTH-1:0]         i_data_alu_out2,
  input  logic                     i_pop_req,
  input  logic                     i_done,
  input  logic                     i_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PUSH1, S_PUSH2} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DW-1:0]     r_sp;
  logic [CW-1:0]     r_cnt;
  logic              r_ready, r_done, r_err, r_push_err, r_put1, r_put2;
  logic [WIDTH-1:0]  r_din1, r_din2, r_cap_d1, r_cap_d2;
  logic              r_cap_err, r_cap_o1, r_cap_o2;

  logic [DW-1:0]     w_nargs;
  logic [AW-1:0]     w_idx1, w_idx2;
  logic              w_full, w_we;
  logic [WIDTH-1:0]  w_wdata;

  assign w_nargs = (i_exec_nargs == 2'd3) ? DW'(2) : DW'(i_exec_nargs);
  assign w_idx1  = AW'(r_sp - DW'(1));
  assign w_idx2  = AW'(r_sp - DW'(2));
  assign w_full  = (r_sp == DW'(DEPTH));

  // Single write port shared by external pushes and result write-back.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = i_push_data;
    case (r_state)
      S_IDLE:  w_we = r_ready && !i_exec_valid && i_push_valid && !w_full;
      S_PUSH1: begin w_we = !r_cap_err && r_cap_o1 && !w_full; w_wdata = r_cap_d1; end
      S_PUSH2: begin w_we = r_cap_o2 && !w_full; w_wdata = r_cap_d2; end
      default: ;
    endcase
  end

  always_ff @(posedge i_gclk)
    if (i_grst_n && w_we) r_mem[r_sp[AW-1:0]] <= w_wdata;

  always_ff @(posedge i_gclk) begin
    if (!i_grst_n) begin
      r_state <= S_IDLE;  r_sp <= '0;       r_cnt <= '0;
      r_ready <= 1'b0;    r_done <= 1'b0;   r_err <= 1'b0;   r_push_err <= 1'b0;
      r_put1 <= 1'b0;     r_put2 <= 1'b0;   r_din1 <= '0;    r_din2 <= '0;
      r_cap_err <= 1'b0;  r_cap_o1 <= 1'b0; r_cap_o2 <= 1'b0;
      r_cap_d1 <= '0;     r_cap_d2 <= '0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_push_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && i_exec_valid) begin
            r_ready <= 1'b0;
            if (w_nargs > r_sp) begin
              r_cap_err <= 1'b1;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
              r_state   <= S_PUSH1;
            end else begin
              r_sp      <= r_sp - w_nargs;
              r_din1    <= r_mem[w_idx1];
              r_din2    <= r_mem[w_idx2];
              r_put1    <= (w_nargs != '0);
              r_put2    <= (w_nargs == DW'(2));
              r_cnt     <= '0;
              r_cap_err <= 1'b0;
              r_state   <= S_WAIT;
            end
          end else if (r_ready && i_push_valid) begin
            if (w_we) r_sp <= r_sp + DW'(1);
            else      r_push_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_done) begin
            r_cap_o1  <= i_put_alu_out1;
            r_cap_o2  <= i_put_alu_out2;
            r_cap_d1  <= i_data_alu_out1;
            r_cap_d2  <= i_data_alu_out2;
            r_cap_err <= i_error;
            r_put1    <= 1'b0;
            r_put2    <= 1'b0;
            r_state   <= S_PUSH1;
            // Completion is flagged here unless a second result still follows.
            r_done    <= i_error || !i_put_alu_out2;
            r_err     <= i_error || (!i_put_alu_out2 && i_put_alu_out1 && w_full);
          end else if (i_pop_req && r_sp != '0) begin
            r_sp   <= r_sp - DW'(1);
            r_din1 <= r_mem[w_idx1];
            r_put1 <= 1'b1;
          end else if (i_pop_req || r_cnt == CW'(TIMEOUT - 1)) begin
            r_cap_err <= 1'b1;
            r_put1    <= 1'b0;
            r_put2    <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_PUSH1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PUSH1: begin
          if (w_we) r_sp <= r_sp + DW'(1);
          if (r_cap_err || !r_cap_o2) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_err   <= w_full || (r_cap_o1 && r_sp == DW'(DEPTH - 1));
            r_state <= S_PUSH2;
          end
        end
        S_PUSH2: begin
          if (w_we) r_sp <= r_sp + DW'(1);
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_exec_ready   = r_ready;
  assign o_exec_done    = r_done;
  assign o_exec_error   = r_err;
  assign o_push_error   = r_push_err;
  assign o_depth        = r_sp;
  assign o_put_alu_in1  = r_put1;
  assign o_put_alu_in2  = r_put2;
  assign o_data_alu_in1 = r_din1;
  assign o_data_alu_in2 = r_din2;
endmodule
